// File: rtl/approx_seq_multiplier.sv
// approx_seq_multiplier
//   Sequential 8x8 unsigned shift-and-add multiplier. Each RUN cycle feeds the
//   accumulator and the (isolated) shifted multiplicand into one 16-bit
//   segmented approximate adder, whose carry mask is latched per operation.
//
//   Ports:
//     clk      rising-edge clock
//     rst      synchronous active-high reset
//     start    begin a multiply (sampled in IDLE only)
//     a, b     8-bit unsigned multiplicand / multiplier (sampled with start)
//     mask     3-bit adder accuracy mask (sampled with start)
//     busy     high while an operation is in progress
//     done     one-cycle pulse when product is updated
//     product  last completed 16-bit approximate product
//
// Also contains the adder and its 4-bit segment slice.

// ---------------------------------------------------------------------------
// One 4-bit adder segment: plain ripple add with carry in/out.
// ---------------------------------------------------------------------------
module approx_add_seg (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
endmodule

// ---------------------------------------------------------------------------
// sixteen_bit_low_power_yet_high_speed_approximate_adder
//   16-bit adder built from four 4-bit segments. mask[k] lets the carry out
//   of segment k into segment k+1; a 0 drops that carry, which both shortens
//   the critical path and makes the sum approximate. mask=3'b111 is exact
//   (modulo 2^16). The carry out of the top segment is discarded.
//   Ports: in1, in2 (16b operands), mask (3b), out (16b sum).
// ---------------------------------------------------------------------------
module sixteen_bit_low_power_yet_high_speed_approximate_adder (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [2:0]  mask,
    output logic [15:0] out
);
    localparam int NUM_SEG = 4;
    localparam int SEG_W   = 4;

    logic [NUM_SEG-1:0] ci;
    logic [NUM_SEG-1:0] co;
    logic               unused_cout;

    genvar g;
    generate
        for (g = 0; g < NUM_SEG; g++) begin : g_seg
            if (g == 0) begin : g_cin0
                assign ci[g] = 1'b0;
            end else begin : g_cinm
                // gated inter-segment carry
                assign ci[g] = co[g-1] & mask[g-1];
            end
            approx_add_seg u_seg (
                .x    (in1[g*SEG_W +: SEG_W]),
                .y    (in2[g*SEG_W +: SEG_W]),
                .cin  (ci[g]),
                .s    (out[g*SEG_W +: SEG_W]),
                .cout (co[g])
            );
        end
    endgenerate

    // Sum is truncated to 16 bits.
    assign unused_cout = co[NUM_SEG-1];
endmodule

// ---------------------------------------------------------------------------
// Top: multiplier FSM.
// ---------------------------------------------------------------------------
module approx_seq_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [2:0]  mask,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] acc;
    logic [2:0]  cnt;
    logic [2:0]  mask_r;

    logic [15:0] add_in2;
    logic [15:0] add_out;
    logic [15:0] acc_next;

    // Operand isolation: the adder sees zero on in2 whenever the current
    // multiplier bit is clear, so it does not toggle needlessly.
    assign add_in2  = mplier[0] ? mcand : 16'h0000;
    assign acc_next = mplier[0] ? add_out : acc;

    sixteen_bit_low_power_yet_high_speed_approximate_adder u_add (
        .in1  (acc),
        .in2  (add_in2),
        .mask (mask_r),
        .out  (add_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 16'h0000;
            mcand   <= 16'h0000;
            mplier  <= 8'h00;
            acc     <= 16'h0000;
            cnt     <= 3'd0;
            mask_r  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {8'h00, a};
                        mplier <= b;
                        acc    <= 16'h0000;
                        cnt    <= 3'd0;
                        mask_r <= mask;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // start is ignored here; all 8 iterations always run
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        product <= acc_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_seq_multiplier.sv
// Randomized scoreboard bench for approx_seq_multiplier. Expected products
// come from a cycle-free reference: an arithmetic nibble-adder model with
// masked inter-nibble carries, chained over the set bits of b.
module tb_approx_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic [2:0]  mask = 3'd0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int passes = 0;
    logic [15:0] sb[$];
    logic        rst_q = 1'b1;
    logic [15:0] prev_product = 16'h0000;

    approx_seq_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .mask    (mask),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    // Approximate add: four nibble additions, carry from nibble k into k+1
    // only when m[k] is set; top carry is lost.
    function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic [2:0] m);
        int c = 0;
        int s;
        logic [15:0] r = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            s = int'((x >> (4 * k)) & 16'hF) + int'((y >> (4 * k)) & 16'hF) + c;
            r = r | (16'(s % 16) << (4 * k));
            c = (k < 3 && m[k]) ? s / 16 : 0;
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                            input logic [2:0] m);
        logic [15:0] acc = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (y[i]) acc = ref_add(acc, 16'(x) << i, m);
        return acc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on each done pulse and checks invariants.
    always @(negedge clk) begin
        if (!rst_q) begin
            check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done) begin
                if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else check("product", {16'd0, product}, {16'd0, sb.pop_front()});
            end else begin
                check("product_stable", {16'd0, product}, {16'd0, prev_product});
            end
        end
        prev_product = product;
    end

    // Issue one multiply starting at a negedge; returns at the negedge where
    // done is seen (or after a reset abort / timeout). inj_at>0 pulses a
    // stray start at that negedge; rst_at>0 asserts reset at that negedge.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] m,
                          input int inj_at, input int rst_at, input bit chk_in2);
        int nbusy = 0;
        start = 1'b1; a = x; b = y; mask = m;
        sb.push_back(ref_mul(x, y, m));
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == inj_at) begin
                start = 1'b1; a = ~x; b = ~y; mask = ~m;
            end
            if (busy) nbusy++;
            if (chk_in2 && busy) check("in2_isolated", {16'd0, dut.add_in2}, 32'd0);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_done", {31'd0, done}, 32'd0);
                check("abort_product", {16'd0, product}, 32'd0);
                rst = 1'b0;
                void'(sb.pop_back());
                return;
            end
            if (done) begin
                check("latency", k - 1, 8);
                check("busy_cycles", nbusy, 8);
                return;
            end
        end
        check("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h03, 8'h05, 3'b111, 0, 0, 0);
        run_op(8'h11, 8'h11, 3'b111, 0, 0, 0);
        check("const_0121", {16'd0, product}, 32'h0121);
        run_op(8'hFF, 8'h01, 3'b111, 0, 0, 0);
        check("const_00ff_a", {16'd0, product}, 32'h00FF);
        run_op(8'h01, 8'hFF, 3'b111, 0, 0, 0);
        check("const_00ff_b", {16'd0, product}, 32'h00FF);
        run_op(8'hA7, 8'h00, 3'b101, 0, 0, 1);
        check("zero_b", {16'd0, product}, 32'h0000);
        run_op(8'h00, 8'hC3, 3'b111, 0, 0, 0);
        check("zero_a", {16'd0, product}, 32'h0000);
        run_op(8'hFF, 8'hFF, 3'b111, 0, 0, 0);
        check("exact_max", {16'd0, product}, 32'hFE01);

        // stray start in RUN cycle 3, then back-to-back (run_op returns in
        // the done cycle and the next call raises start there)
        run_op(8'h5A, 8'hC7, 3'b011, 4, 0, 0);
        run_op(8'h9B, 8'h6D, 3'b110, 0, 0, 0);

        // reset in RUN cycle 4, then a clean op
        @(negedge clk);
        run_op(8'hE3, 8'hB9, 3'b111, 5, 5, 0);
        run_op(8'h03, 8'h05, 3'b111, 0, 0, 0);
        check("after_abort", {16'd0, product}, 32'h000F);

        for (int m = 0; m < 8; m++)
            for (int n = 0; n < 6; n++)
                run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'(m), 0, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
